load_store_unit: RTL
====================

# load_store_unit

Multicycle load/store unit sitting directly downstream of the control unit's MEMORY/WRITE_BACK states, between the datapath and the unified word-wide memory. It takes a one-cycle access request with effective address, store data and funct3. It performs byte/halfword/word loads with sign or zero extension, and sub-word stores via read-modify-write on a memory without byte enables. It returns a one-cycle `done` pulse and the extended load result for register write-back.

## Interface
- `ADDR_W`, 32: effective-address width; memory word address is `ADDR_W-2` bits.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request strobe from control; sampled only in IDLE.
- `is_store` input 1: 1 = store (control's `mem_write` intent), 0 = load.
- `funct3` input 3: access size/sign, instr[14:12].
- `addr` input ADDR_W: effective byte address (ALU result).
- `wdata` input 32: store data (rs2).
- `rdata` output 32: extended load result; holds until the next load completes.
- `done` output 1: one-cycle completion pulse.
- `busy` output 1: high in every non-IDLE state.
- `misaligned` output 1: pulses with `done` for a misaligned access.
- `mem_addr` output ADDR_W-2: word address = latched addr[ADDR_W-1:2].
- `mem_re` output 1: memory read enable; data is valid on `mem_rdata` the following cycle.
- `mem_we` output 1: memory write enable; writes `mem_wdata` at the edge.
- `mem_wdata` output 32: full word to write.
- `mem_rdata` input 32: memory read data.

## Operation
- States: IDLE, RD, RDW, WR, DONE.
- IDLE with `start`=1: latch addr, wdata, funct3, is_store. Next state:
  - load → RD
  - SW → WR
  - SB/SH → RD
  - misaligned with trap enabled → DONE
- RD: `mem_re`=1. Next state is RDW.
- RDW: capture `mem_rdata`.
  - Load: form `rdata` and go to DONE.
  - SB/SH: form the merged word and go to WR.
- WR: `mem_we`=1, `mem_wdata` = wdata (SW) or the merged word. Next state is DONE.
- DONE: `done`=1. Next state is IDLE.
- Byte lanes are little-endian: lane k = bits [8k+7:8k], selected by addr[1:0]; halfword selected by addr[1].
- Loads:
  - 000 LB: sign-extend lane.
  - 100 LBU: zero-extend lane.
  - 001 LH: sign-extend half.
  - 101 LHU: zero-extend half.
  - 010 LW: whole word.
  - Illegal funct3 (011, 110, 111) is treated as LW.
- Stores:
  - 000 SB: replace lane with wdata[7:0].
  - 001 SH: replace half with wdata[15:0].
  - 010 SW: whole word.
  - Illegal funct3 is treated as SW.
- Misaligned access: halfword with addr[0]=1, or word with addr[1:0]≠0.
- `start` while `busy` is ignored; no queuing.
- `mem_*` outputs are decoded from the state register only (glitch-free relative to inputs).

## Timing
- Reset values: state IDLE; `rdata`=0; `done`, `busy`, `misaligned`, `mem_re`, `mem_we`=0; `mem_addr`=0; `mem_wdata`=0.
- Latency from the `start` cycle (cycle 0) to `done`:
  - Load: RD c1, RDW c2, done c3.
  - SW: WR c1, done c2.
  - SB/SH: RD c1, RDW c2, WR c3, done c4.
  - Misaligned with trap: done c1.
- `rdata` is valid from the `done` cycle onward.
- Back-to-back: a new `start` is accepted in the cycle after DONE (IDLE), never in DONE.
- Reset mid-operation:
  - A write whose WR cycle coincides with `rst_n`=0 still completes at that edge.
  - After that edge there is no further `mem_re`/`mem_we` and no `done`.
- Memory read-to-write turnaround within RMW has no bubble: RDW is followed directly by WR.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses skip memory entirely: no `mem_re`, no `mem_we`.
  - `done` and `misaligned` pulse together one cycle after `start`.
  - `rdata` is unchanged.
- Undefined:
  - Low address bits are forced aligned: halfword clears addr[0], word clears addr[1:0].
  - The access proceeds normally.
  - `misaligned` is tied 0.

## Structure
- `lsu_pkg`: state enum; funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
- Sub-module `lsu_align` (combinational): load extract/extend, store merge, and misalignment detect, from funct3 and addr[1:0].
- FSM and registers live in `load_store_unit`.

## Test plan
- LB at addr 0x103, memory word 0x80AA_BBCC → `rdata`=0xFFFF_FF80, `done` at c3, one `mem_re` pulse.
- LHU at 0x102, word 0x8001_7F00 → `rdata`=0x0000_8001; LH at the same address → 0xFFFF_8001.
- SB at 0x201, wdata 0x0000_00EE, old word 0x1122_3344 → one read, then a write of 0x1122_EE44 at word 0x80, `done` at c4.
- SW at 0x300, wdata 0xDEAD_BEEF → no `mem_re`, `mem_we` at c1, `done` at c2.
- LW at 0x102 with trap enabled → `done` and `misaligned` at c1, no memory activity; with trap disabled → reads word 0x40, `misaligned`=0.
- `start` pulsed during `busy`, then `rst_n`=0 in RDW of an SH → second request ignored, no `mem_we`, no `done`, all outputs at reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RDW  = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Illegal encodings fall back to a full-word access for both loads and stores.
  function automatic lsu_size_e access_size(input logic [2:0] f3, input logic st);
    lsu_size_e sz;
    sz = SZ_W;
    if (st) begin
      if (f3 == F3_B)      sz = SZ_B;
      else if (f3 == F3_H) sz = SZ_H;
    end else begin
      if (f3 == F3_B || f3 == F3_BU)      sz = SZ_B;
      else if (f3 == F3_H || f3 == F3_HU) sz = SZ_H;
    end
    return sz;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend, store merge, misalignment detect.
// The misaligned port exists only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        is_store,
  input  logic [1:0]  offset,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output lsu_size_e   size,
  output logic [31:0] load_result,
  output logic [31:0] merged_word
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misaligned
`endif
);

  logic       mis;
  logic [1:0] lane_off;
  logic [7:0] byte_val;
  logic [15:0] half_val;

  always_comb begin
    size = access_size(funct3, is_store);
    mis  = ((size == SZ_H) && offset[0]) || ((size == SZ_W) && (offset != 2'b00));
    // Misaligned offsets are forced down to the natural boundary of the access.
    lane_off = offset;
    if (size == SZ_H)      lane_off = {offset[1], 1'b0};
    else if (size == SZ_W) lane_off = 2'b00;

    byte_val = mem_word[{lane_off, 3'b000} +: 8];
    half_val = lane_off[1] ? mem_word[31:16] : mem_word[15:0];

    load_result = mem_word;
    case (size)
      SZ_B:    load_result = funct3[2] ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
      SZ_H:    load_result = funct3[2] ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
      default: load_result = mem_word;
    endcase

    merged_word = mem_word;
    case (size)
      SZ_B:    merged_word[{lane_off, 3'b000} +: 8] = store_data[7:0];
      SZ_H:    merged_word[{lane_off[1], 4'b0000} +: 16] = store_data[15:0];
      default: merged_word = store_data;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = mis;
`endif

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit with read-modify-write sub-word stores.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning them.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              busy,
  output logic              misaligned,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, next_state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merged_q;
  logic [2:0]        funct3_q;
  logic              store_q;

  logic [2:0]        sel_funct3;
  logic              sel_store;
  logic [1:0]        sel_offset;
  lsu_size_e         size;
  logic [31:0]       load_result;
  logic [31:0]       merged_word;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              mis_det;
  logic              mis_q;
`endif

  // In IDLE the aligner sees the incoming request; afterwards the latched one.
  assign sel_funct3 = (state == IDLE) ? funct3   : funct3_q;
  assign sel_store  = (state == IDLE) ? is_store : store_q;
  assign sel_offset = (state == IDLE) ? addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .funct3      (sel_funct3),
    .is_store    (sel_store),
    .offset      (sel_offset),
    .mem_word    (mem_rdata),
    .store_data  (wdata_q),
    .size        (size),
    .load_result (load_result),
    .merged_word (merged_word)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misaligned  (mis_det)
`endif
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      merged_q <= '0;
      funct3_q <= '0;
      store_q  <= 1'b0;
      rdata    <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        addr_q   <= addr;
        wdata_q  <= wdata;
        funct3_q <= funct3;
        store_q  <= is_store;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_q    <= mis_det;
`endif
      end
      if (state == RDW) begin
        if (store_q) merged_q <= merged_word;
        else         rdata    <= load_result;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (is_store && size == SZ_W) next_state = WR;
          else                          next_state = RD;
`ifdef LSU_MISALIGN_TRAP_EN
          if (mis_det) next_state = DONE;
`endif
        end
      end
      RD:      next_state = RDW;
      RDW:     next_state = store_q ? WR : DONE;
      WR:      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Memory strobes come straight from the state register so they never glitch on inputs.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_re    = (state == RD);
  assign mem_we    = (state == WR);
  assign mem_addr  = addr_q[ADDR_W-1:2];
  assign mem_wdata = (state == WR) ? ((size == SZ_W) ? wdata_q : merged_q) : 32'h0;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = (state == DONE) && mis_q;
`else
  assign misaligned = 1'b0;
`endif

endmodule
